// File: rtl/pwm_ramp_ctrl.sv
// PWM ramp sequencer: prescaled CE, frame tracking and
// frame-aligned duty-code ramping toward a latched target.
module pwm_ramp_ctrl #(
  parameter int UDW = 4,
  parameter int PDW = 16,
  parameter int HDW = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           SRST,
  input  logic           START,
  input  logic           STOP,
  input  logic [UDW-1:0] TGT_CODE,
  input  logic [PDW-1:0] PRESC,
  input  logic [HDW-1:0] HOLD,
  output logic           PWM_CE,
  output logic           PWM_RE,
  output logic [UDW-1:0] PWM_CODE,
  output logic           PERIOD_END,
  output logic           BUSY,
  output logic           DONE
);

  typedef enum logic [1:0] {
    IDLE, RAMP, RUN, STOPPING
  } state_t;

  state_t         state, state_n;
  logic [PDW-1:0] pcnt, pcnt_n;
  logic [UDW-1:0] fcnt, fcnt_n;
  logic [UDW-1:0] tgt, tgt_n, code_n;
  logic [UDW-1:0] dir_tgt, step_code;
  logic [HDW-1:0] hcnt, hcnt_n;
  logic [HDW-1:0] hold_l, hold_n, hold_in;
  logic           ce_n, pe_n, re_n;
  logic           done_n, busy_n;
  logic           fe, step_due;

  assign fe       = PWM_CE && (fcnt == '1);
  assign step_due = fe && (hcnt <= HDW'(1));
  assign hold_in  = (HOLD == '0) ? HDW'(1) : HOLD;
  assign dir_tgt  = (state == STOPPING) ? '0 : tgt;

  always_comb begin
    step_code = PWM_CODE;
    if (PWM_CODE < dir_tgt)
      step_code = PWM_CODE + UDW'(1);
    else if (PWM_CODE > dir_tgt)
      step_code = PWM_CODE - UDW'(1);
  end

  always_comb begin
    state_n = state;
    code_n  = PWM_CODE;
    tgt_n   = tgt;
    hold_n  = hold_l;
    hcnt_n  = hcnt;
    re_n    = PWM_RE;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (START && !STOP) begin
          tgt_n   = TGT_CODE;
          hold_n  = hold_in;
          hcnt_n  = hold_in;
          re_n    = 1'b0;
          state_n = RAMP;
          if (TGT_CODE == PWM_CODE) begin
            state_n = RUN;
            done_n  = 1'b1;
          end
        end
      end
      RAMP, RUN, STOPPING: begin
        if (STOP && state != STOPPING) begin
          state_n = STOPPING;
          hcnt_n  = hold_l;
        end else if (START && !STOP) begin
          tgt_n   = TGT_CODE;
          hold_n  = hold_in;
          hcnt_n  = hold_in;
          state_n = RAMP;
          if (TGT_CODE == PWM_CODE) begin
            state_n = RUN;
            done_n  = 1'b1;
          end
        end else if (state == RAMP && fe) begin
          if (step_due) begin
            code_n = step_code;
            hcnt_n = hold_l;
            if (step_code == tgt) begin
              state_n = RUN;
              done_n  = 1'b1;
            end
          end else begin
            hcnt_n = hcnt - HDW'(1);
          end
        end else if (state == STOPPING && fe) begin
          // already at zero: leave on this frame boundary
          if (PWM_CODE == '0 || (step_due && step_code == '0)) begin
            code_n  = '0;
            state_n = IDLE;
            re_n    = 1'b1;
          end else if (step_due) begin
            code_n = step_code;
            hcnt_n = hold_l;
          end else begin
            hcnt_n = hcnt - HDW'(1);
          end
        end
      end
    endcase
    busy_n = (state_n == RAMP) || (state_n == STOPPING);
  end

  // counters stay cleared while the generator is held in reset
  always_comb begin
    pcnt_n = '0;
    fcnt_n = '0;
    ce_n   = 1'b0;
    pe_n   = 1'b0;
    if (!PWM_RE && !re_n) begin
      ce_n   = (pcnt >= PRESC);
      pcnt_n = ce_n ? '0 : pcnt + PDW'(1);
      fcnt_n = PWM_CE ? fcnt + UDW'(1) : fcnt;
      pe_n   = ce_n && (fcnt_n == '1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      pcnt       <= '0;
      fcnt       <= '0;
      hcnt       <= '0;
      tgt        <= '0;
      hold_l     <= HDW'(1);
      PWM_CE     <= 1'b0;
      PWM_RE     <= 1'b1;
      PWM_CODE   <= '0;
      PERIOD_END <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else if (SRST) begin
      state      <= IDLE;
      pcnt       <= '0;
      fcnt       <= '0;
      hcnt       <= '0;
      tgt        <= '0;
      hold_l     <= HDW'(1);
      PWM_CE     <= 1'b0;
      PWM_RE     <= 1'b1;
      PWM_CODE   <= '0;
      PERIOD_END <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      state      <= state_n;
      pcnt       <= pcnt_n;
      fcnt       <= fcnt_n;
      hcnt       <= hcnt_n;
      tgt        <= tgt_n;
      hold_l     <= hold_n;
      PWM_CE     <= ce_n;
      PWM_RE     <= re_n;
      PWM_CODE   <= code_n;
      PERIOD_END <= pe_n;
      BUSY       <= busy_n;
      DONE       <= done_n;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: expected code/DONE
// events with cycle stamps, frame-grid and reset checks.
module tb_pwm_ramp_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        SRST = 1'b0;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic [3:0]  TGT_CODE = '0;
  logic [15:0] PRESC = '0;
  logic [7:0]  HOLD = 8'd1;
  logic        PWM_CE, PWM_RE, PERIOD_END, BUSY, DONE;
  logic [3:0]  PWM_CODE;

  pwm_ramp_ctrl #(.UDW(4), .PDW(16), .HDW(8)) dut (
    .CLK(CLK), .RST(RST), .SRST(SRST),
    .START(START), .STOP(STOP),
    .TGT_CODE(TGT_CODE), .PRESC(PRESC), .HOLD(HOLD),
    .PWM_CE(PWM_CE), .PWM_RE(PWM_RE),
    .PWM_CODE(PWM_CODE), .PERIOD_END(PERIOD_END),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] code;
    logic       done;
    int         t;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  bit         grid_on = 1'b0;
  bit         watch_re = 1'b0;
  bit         re_hi = 1'b0;
  int         grid_base = 0;
  int         grid_per = 16;
  logic [3:0] last_code = '0;
  int         s, n;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (PWM_CODE !== last_code || DONE) begin
        if (exp_q.size() == 0) begin
          chk("unexp_evt", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("evt_code", PWM_CODE, mon_e.code);
          chk("evt_done", DONE, mon_e.done);
          chk("evt_time", cyc, mon_e.t);
        end
      end
      if (grid_on && PERIOD_END) begin
        chk("pe_grid", (cyc - grid_base) % grid_per, 0);
        chk("pe_ce", PWM_CE, 1);
      end
    end
    if (watch_re && PWM_RE) re_hi = 1'b1;
    last_code = PWM_CODE;
  end

  // cycle at which the first step after a request at edge s shows
  function automatic int next_step(input int st, input int h);
    int m;
    m = (st - grid_base + grid_per - 1) / grid_per;
    if (m < 1) m = 1;
    return grid_base + grid_per * m + grid_per * (h - 1) + 1;
  endfunction

  task automatic push_ramp(input int st, input int from,
                           input int to, input int h,
                           input bit dn);
    ev_t e;
    int  t;
    int  c;
    t = next_step(st, h);
    c = from;
    while (c != to) begin
      c = (to > c) ? c + 1 : c - 1;
      e.code = 4'(c);
      e.done = dn && (c == to);
      e.t    = t;
      exp_q.push_back(e);
      t += grid_per * h;
    end
  endtask

  task automatic req(input bit st, input bit sp,
                     input logic [3:0] tg);
    TGT_CODE = tg;
    START    = st;
    STOP     = sp;
    @(negedge CLK);
    START = 1'b0;
    STOP  = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge CLK);
      k++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_re", PWM_RE, 1);
    chk("rst_ce", PWM_CE, 0);
    chk("rst_code", PWM_CODE, 0);
    chk("rst_pe", PERIOD_END, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("idle_re", PWM_RE, 1);
    mon_en = 1'b1;

    // ramp up 0->3, CE every 2nd clock, 2 frames per step
    PRESC = 16'd1;
    HOLD  = 8'd2;
    s = cyc + 1;
    grid_base = s;
    grid_per  = 32;
    grid_on   = 1'b1;
    push_ramp(s, 0, 3, 2, 1'b1);
    req(1'b1, 1'b0, 4'd3);
    chk("t1_busy", BUSY, 1);
    chk("t1_re", PWM_RE, 0);
    n = 0;
    repeat (32) begin
      @(negedge CLK);
      n += int'(PWM_CE);
    end
    chk("t1_ce_cnt", n, 16);
    drain(400);
    chk("t1_code", PWM_CODE, 3);
    chk("t1_busy_end", BUSY, 0);

    // ramp down 3->1 from RUN, generator never reset
    s = cyc + 1;
    push_ramp(s, 3, 1, 2, 1'b1);
    re_hi    = 1'b0;
    watch_re = 1'b1;
    req(1'b1, 1'b0, 4'd1);
    drain(400);
    watch_re = 1'b0;
    chk("t2_re_low", re_hi, 0);
    chk("t2_code", PWM_CODE, 1);

    // target equal to current code
    s = cyc + 1;
    exp_q.push_back('{code: 4'd1, done: 1'b1, t: s});
    req(1'b1, 1'b0, 4'd1);
    drain(10);
    chk("t4_eq_busy", BUSY, 0);

    // START and STOP together: STOP wins
    s = cyc + 1;
    push_ramp(s, 1, 0, 2, 1'b0);
    req(1'b1, 1'b1, 4'd3);
    chk("t4_stop_busy", BUSY, 1);
    chk("t4_stop_code", PWM_CODE, 1);
    drain(400);
    chk("t4_idle_re", PWM_RE, 1);
    chk("t4_idle_busy", BUSY, 0);
    grid_on = 1'b0;

    // up to 5 then STOP back to 0
    PRESC = 16'd0;
    HOLD  = 8'd1;
    @(negedge CLK);
    s = cyc + 1;
    grid_base = s;
    grid_per  = 16;
    grid_on   = 1'b1;
    push_ramp(s, 0, 5, 1, 1'b1);
    req(1'b1, 1'b0, 4'd5);
    drain(300);
    chk("t3_code5", PWM_CODE, 5);
    s = cyc + 1;
    push_ramp(s, 5, 0, 1, 1'b0);
    req(1'b0, 1'b1, 4'd0);
    drain(300);
    chk("t3_re", PWM_RE, 1);
    chk("t3_busy", BUSY, 0);
    chk("t3_code0", PWM_CODE, 0);
    @(negedge CLK);
    chk("t3_ce_idle", PWM_CE, 0);
    grid_on = 1'b0;

    // HOLD=0 behaves as 1, CE every cycle
    HOLD = 8'd0;
    s = cyc + 1;
    grid_base = s;
    grid_on   = 1'b1;
    push_ramp(s, 0, 2, 1, 1'b1);
    req(1'b1, 1'b0, 4'd2);
    drain(200);
    n = 0;
    repeat (16) begin
      @(negedge CLK);
      n += int'(PWM_CE);
    end
    chk("t5_ce_cnt", n, 16);
    s = cyc + 1;
    push_ramp(s, 2, 0, 1, 1'b0);
    req(1'b0, 1'b1, 4'd0);
    drain(200);
    grid_on = 1'b0;

    // async reset mid-ramp
    @(negedge CLK);
    req(1'b1, 1'b0, 4'd9);
    mon_en = 1'b0;
    exp_q.delete();
    repeat (40) @(negedge CLK);
    chk("t6_mid_code", PWM_CODE, 2);
    #2 RST = 1'b1;
    #1;
    chk("t6_rst_re", PWM_RE, 1);
    chk("t6_rst_code", PWM_CODE, 0);
    chk("t6_rst_busy", BUSY, 0);
    chk("t6_rst_ce", PWM_CE, 0);
    chk("t6_rst_done", DONE, 0);
    @(negedge CLK);
    RST = 1'b0;

    // sync reset mid-ramp
    req(1'b1, 1'b0, 4'd9);
    repeat (40) @(negedge CLK);
    chk("t6_mid_code2", PWM_CODE, 2);
    SRST = 1'b1;
    #1;
    chk("t6_srst_pre", PWM_RE, 0);
    @(posedge CLK);
    #1;
    chk("t6_srst_re", PWM_RE, 1);
    chk("t6_srst_code", PWM_CODE, 0);
    chk("t6_srst_busy", BUSY, 0);
    chk("t6_srst_ce", PWM_CE, 0);
    chk("t6_srst_pe", PERIOD_END, 0);
    @(negedge CLK);
    SRST = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge CLK);
      n += int'(DONE);
    end
    chk("t6_no_done", n, 0);
    chk("t6_end_re", PWM_RE, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
